sd_cmd_sequencer: RTL

SD_CMD_SEQUENCER -- requirements
Module: sd_cmd_sequencer

---
 rtl/sd_seq_pkg.sv | 24 ++
 rtl/sd_reg_burst.sv | 51 +++++
 rtl/sd_cmd_sequencer.sv | 119 +++++++++++
 3 files changed

// File: rtl/sd_seq_pkg.sv
// sd_seq_pkg: states, sdc_controller register map, command codes and status bits
// shared by the SD command sequencer and its register-burst writer.
package sd_seq_pkg;
  typedef enum logic [2:0] {S_POWERUP, S_ISSUE, S_GAP, S_POLL, S_IDLE, S_ERROR} state_e;
  typedef enum logic [7:0] {CMD0 = 8'd0, CMD7 = 8'd7, CMD17 = 8'd17} cmd_e;
  localparam logic [6:0] REG_TRIG   = 7'd0;
  localparam logic [6:0] REG_ARG0   = 7'd1;
  localparam logic [6:0] REG_ARG1   = 7'd2;
  localparam logic [6:0] REG_ARG2   = 7'd3;
  localparam logic [6:0] REG_ARG3   = 7'd4;
  localparam logic [6:0] REG_CMD    = 7'd5;
  localparam logic [6:0] REG_STATUS = 7'd6;
  localparam int ST_BUSY = 0;
  localparam int ST_ERR  = 1;
  // Beat idx of a command burst as {addr, data}: command, argument MSB..LSB, trigger.
  function automatic logic [14:0] burst_beat(input logic [2:0] idx, input logic [7:0] cmd,
                                             input logic [31:0] arg);
    return idx == 3'd0 ? {REG_CMD, cmd} :
           idx == 3'd1 ? {REG_ARG3, arg[31:24]} :
           idx == 3'd2 ? {REG_ARG2, arg[23:16]} :
           idx == 3'd3 ? {REG_ARG1, arg[15:8]} :
           idx == 3'd4 ? {REG_ARG0, arg[7:0]} : {REG_TRIG, 8'd0};
  endfunction
endpackage

// File: rtl/sd_reg_burst.sv
// sd_reg_burst: emits the six consecutive registered writes of one SD command;
// done is high during the trigger write.
module sd_reg_burst
  import sd_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  cmd_e        cmd,
  input  logic [31:0] arg,
  output logic        busy,
  output logic        done,
  output logic [6:0]  reg_addr,
  output logic [7:0]  reg_wdata
);
  logic        r_busy;
  logic [2:0]  r_idx;
  cmd_e        r_cmd;
  logic [31:0] r_arg;
  logic [6:0]  r_addr;
  logic [7:0]  r_wdata;
  logic        w_adv;
  logic [2:0]  w_idx;
  cmd_e        w_cmd;
  logic [31:0] w_arg;
  assign done  = r_busy && r_idx == 3'd5;
  assign w_adv = start || (r_busy && !done);
  assign w_idx = start ? 3'd0 : r_idx + 3'd1;
  assign w_cmd = start ? cmd : r_cmd;
  assign w_arg = start ? arg : r_arg;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_busy  <= 1'b0;
      r_idx   <= '0;
      r_cmd   <= CMD0;
      r_arg   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_busy <= w_adv;
      if (w_adv) begin
        r_idx             <= w_idx;
        r_cmd             <= w_cmd;
        r_arg             <= w_arg;
        {r_addr, r_wdata} <= burst_beat(w_idx, w_cmd, w_arg);
      end
    end
  assign busy      = r_busy;
  assign reg_addr  = r_addr;
  assign reg_wdata = r_wdata;
endmodule

// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer: SD bring-up (CMD0, gap, CMD7 with status poll) followed by
// CMD17 block-read requests, driven through the sdc_controller register port.
module sd_cmd_sequencer
  import sd_seq_pkg::*;
#(
  parameter int          POWERUP_CYC = 64,
  parameter int          CMD0_GAP    = 256,
  parameter int          TIMEOUT     = 4096,
  parameter logic [31:0] RCA_ARG     = 32'h0000_1300
) (
  input  logic        clk,
  input  logic        rstn_async,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_lba,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic        init_done,
  output logic        init_err,
  output logic [6:0]  reg_addr,
  output logic        reg_we,
  output logic [7:0]  reg_wdata,
  input  logic [7:0]  reg_rdata
);
  localparam int CMAX = POWERUP_CYC > CMD0_GAP ? (POWERUP_CYC > TIMEOUT ? POWERUP_CYC : TIMEOUT)
                                               : (CMD0_GAP > TIMEOUT ? CMD0_GAP : TIMEOUT);
  localparam int CW = $clog2(CMAX + 1);
  logic [1:0]    r_sync;
  logic          w_rst_n;
  state_e        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  cmd_e          r_cmd, w_cmd;
  logic [31:0]   w_arg;
  logic          r_init_done, w_init_done, r_init_err, w_init_err;
  logic          r_rsp_valid, w_rsp_valid, r_rsp_err, w_rsp_err;
  logic          w_start, w_busy, w_done, w_fail;
  logic [6:0]    w_baddr;
  logic [7:0]    w_bdata;
  // Assertion reaches every flop at once; release is delayed by two clocks.
  always_ff @(posedge clk or negedge rstn_async)
    if (!rstn_async) r_sync <= 2'b00;
    else r_sync <= {r_sync[0], 1'b1};
  assign w_rst_n = r_sync[1];
  sd_reg_burst u_burst (
    .clk(clk), .rst_n(w_rst_n), .start(w_start), .cmd(w_cmd), .arg(w_arg),
    .busy(w_busy), .done(w_done), .reg_addr(w_baddr), .reg_wdata(w_bdata)
  );
  // A sample still busy at the last allowed poll counts as a timeout failure.
  assign w_fail = reg_rdata[ST_BUSY] | reg_rdata[ST_ERR];
  always_comb begin
    w_state     = r_state;
    w_cnt       = '0;
    w_cmd       = r_cmd;
    w_arg       = '0;
    w_start     = 1'b0;
    w_init_done = r_init_done;
    w_init_err  = r_init_err;
    w_rsp_valid = 1'b0;
    w_rsp_err   = 1'b0;
    case (r_state)
      S_POWERUP:
        if (r_cnt == CW'(POWERUP_CYC - 1)) begin
          w_start = 1'b1;
          w_cmd   = CMD0;
          w_state = S_ISSUE;
        end else w_cnt = r_cnt + CW'(1);
      S_ISSUE: if (w_done) w_state = r_cmd == CMD0 ? S_GAP : S_POLL;
      S_GAP:
        if (r_cnt == CW'(CMD0_GAP - 1)) begin
          w_start = 1'b1;
          w_cmd   = CMD7;
          w_arg   = RCA_ARG;
          w_state = S_ISSUE;
        end else w_cnt = r_cnt + CW'(1);
      S_POLL:
        if (r_cnt != '0 && (!reg_rdata[ST_BUSY] || r_cnt == CW'(TIMEOUT))) begin
          w_rsp_valid = r_cmd == CMD17;
          w_rsp_err   = r_cmd == CMD17 && w_fail;
          w_init_done = r_init_done || (r_cmd == CMD7 && !w_fail);
          w_init_err  = r_init_err || (r_cmd == CMD7 && w_fail);
          w_state     = r_cmd == CMD7 && w_fail ? S_ERROR : S_IDLE;
        end else w_cnt = r_cnt + CW'(1);
      S_IDLE:
        if (req_valid) begin
          w_start = 1'b1;
          w_cmd   = CMD17;
          w_arg   = req_lba;
          w_state = S_ISSUE;
        end
      default: w_state = r_state;
    endcase
  end
  always_ff @(posedge clk or negedge w_rst_n)
    if (!w_rst_n) begin
      r_state     <= S_POWERUP;
      r_cnt       <= '0;
      r_cmd       <= CMD0;
      r_init_done <= 1'b0;
      r_init_err  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_cmd       <= w_cmd;
      r_init_done <= w_init_done;
      r_init_err  <= w_init_err;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_err   <= w_rsp_err;
    end
  assign req_ready = r_state == S_IDLE;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign init_done = r_init_done;
  assign init_err  = r_init_err;
  assign reg_we    = w_busy;
  assign reg_addr  = w_busy ? w_baddr : (r_state == S_POLL ? REG_STATUS : '0);
  assign reg_wdata = w_busy ? w_bdata : '0;
endmodule
